// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
// Module : huffman_decoder
// Serial MSB-first Huffman decoder: loads a 6-slot code/mask table, shifts in
// code bits and emits the matched symbol index (1..NSYM) as a one-cycle strobe.
// Rev    : 1.0
// ============================================================================
module huffman_decoder #(
   parameter int NSYM = 6,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              code_valid,
   input  logic [NSYM*W-1:0] HC,
   input  logic [NSYM*W-1:0] M,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              bit_ready,
   output logic              gray_valid,
   output logic [7:0]        gray_data,
   output logic              err
);

   localparam int LW = $clog2(W + 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      READY = 2'd1,
      ACCUM = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   hc_tab  [NSYM];
   logic [W-1:0]   m_tab   [NSYM];
   logic [LW-1:0]  len_tab [NSYM];

   // A partial codeword never exceeds W-1 bits, so acc needs only W-1 bits.
   logic [W-2:0]   acc, acc_nx;
   logic [W-1:0]   acc_sh;
   logic [LW-1:0]  len, len_nx, len_inc;
   logic [NSYM-1:0] hit;
   logic           any_hit;
   logic [7:0]     hit_sym;
   logic           gv_nx, err_nx;
   logic [7:0]     gd_nx;

   function automatic logic [LW-1:0] popcount(input logic [W-1:0] v);
      logic [LW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         c = c + LW'(v[i]);
      end
      return c;
   endfunction

   // Slot k (0-based) sits at the k-th byte from the MSB end of HC/M.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NSYM; k++) begin
            hc_tab[k]  <= '0;
            m_tab[k]   <= '0;
            len_tab[k] <= '0;
         end
      end else if (code_valid) begin
         for (int k = 0; k < NSYM; k++) begin
            hc_tab[k]  <= HC[(NSYM-1-k)*W +: W];
            m_tab[k]   <= M[(NSYM-1-k)*W +: W];
            len_tab[k] <= popcount(M[(NSYM-1-k)*W +: W]);
         end
      end
   end

   assign acc_sh  = {acc, bit_in};
   assign len_inc = len + LW'(1);

   generate
      for (genvar k = 0; k < NSYM; k++) begin : g_slot
         assign hit[k] = (len_tab[k] != '0) && (len_inc == len_tab[k]) &&
                         (acc_sh == (hc_tab[k] & m_tab[k]));
      end
   endgenerate

   // Scan downward so the lowest matching slot is the one left standing.
   always_comb begin
      any_hit = 1'b0;
      hit_sym = '0;
      for (int k = NSYM - 1; k >= 0; k--) begin
         if (hit[k]) begin
            any_hit = 1'b1;
            hit_sym = 8'(k + 1);
         end
      end
   end

   always_comb begin
      state_n = state;
      acc_nx  = acc;
      len_nx  = len;
      gv_nx   = 1'b0;
      err_nx  = 1'b0;
      gd_nx   = gray_data;
      if (code_valid) begin
         state_n = READY;
         acc_nx  = '0;
         len_nx  = '0;
      end else if (state != EMPTY && bit_valid) begin
         if (any_hit) begin
            gv_nx   = 1'b1;
            gd_nx   = hit_sym;
            state_n = READY;
            acc_nx  = '0;
            len_nx  = '0;
         end else if (len_inc == LW'(W)) begin
            err_nx  = 1'b1;
            state_n = READY;
            acc_nx  = '0;
            len_nx  = '0;
         end else begin
            state_n = ACCUM;
            acc_nx  = acc_sh[W-2:0];
            len_nx  = len_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         acc        <= '0;
         len        <= '0;
         bit_ready  <= 1'b0;
         gray_valid <= 1'b0;
         gray_data  <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         acc        <= acc_nx;
         len        <= len_nx;
         bit_ready  <= bit_ready | code_valid;
         gray_valid <= gv_nx;
         gray_data  <= gd_nx;
         err        <= err_nx;
      end
   end

endmodule
`default_nettype wire

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Receive side of the huffman block. Loads the code table produced by the encoder: 6 codes (HC) plus 6 masks (M), strobed by code_valid.
- Consumes a serial, MSB-first code bitstream and reconstructs the gray symbols 1..6.
- Emits each decoded symbol as gray_data with a one-cycle gray_valid strobe, the same symbol format the encoder consumes. This closes the encode/decode loop for PATTERN-style self-check.

Parameters:
- NSYM, 6, number of symbols / table slots
- W, 8, width of each HC/M slot and maximum code length in bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- code_valid  input  1  one-cycle strobe; load HC/M into the table
- HC  input  48  codes: slot k (1..6) at HC[55-8k:48-8k], i.e. slot 1 is MSB byte; code right-aligned
- M  input  48  masks, same slot layout; contiguous ones from the LSB, popcount = code length
- bit_valid  input  1  bit_in is valid this cycle
- bit_in  input  1  next code bit, MSB of each codeword first
- bit_ready  output  1  table loaded; decoder accepts bits
- gray_valid  output  1  one-cycle strobe; decoded symbol on gray_data
- gray_data  output  8  decoded symbol value k (1..6)
- err  output  1  one-cycle strobe; W bits accumulated with no match

Behaviour:
- Interface: one clock domain (clk). Reset is asynchronous, active-high (reset). All outputs are registered.
- Reset values:
  - bit_ready=0, gray_valid=0, gray_data=8'd0, err=0
  - Table HC/M and per-slot lengths cleared to 0
  - acc=0, len=0, state=EMPTY
- States:
  - EMPTY: no table. bit_valid is ignored and produces no output.
  - READY: table held, acc/len=0.
  - ACCUM: partial codeword held (1 <= len <= W-1).
- Table load: code_valid=1 in any state registers HC, M and len_k=popcount(M_k). It also clears acc/len and moves to READY next cycle, with bit_ready=1 from that cycle.
  - A load mid-codeword silently discards the partial codeword; no err.
  - code_valid and bit_valid in the same cycle: load wins, the bit is dropped.
- Bit accept (READY/ACCUM, bit_valid=1): acc_n={acc[W-2:0],bit_in}, len_n=len+1.
- Match for slot k: len_k!=0 and len_n==len_k and acc_n==(HC_k & M_k).
  - Slots with M_k=0 never match.
  - Multiple matches (non-prefix-free table): lowest k wins.
- On match: the next cycle has gray_valid=1 and gray_data=k. acc/len clear, state goes to READY. Latency is exactly 1 cycle from the final bit.
- No match and len_n==W: the next cycle has err=1 and gray_valid=0. acc/len clear, state goes to READY.
- No match and len_n<W: state goes to ACCUM and accumulates.
- bit_valid=0: no change; gaps between bits of one codeword are legal.
- gray_data holds its last value when gray_valid=0. gray_valid and err are never high together.
- Back-to-back symbols: bits are accepted every cycle with no bubble. A single-bit codeword decodes every cycle.
- Reset asserted mid-operation: immediate return to reset values; the table is lost, so code_valid is required again.

Test Plan:
1. Table load and single symbols.
   - Stimulus: reset, code_valid with HC=48'h01_01_00_02_06_07 and M=48'h01_03_07_0F_1F_1F.
   - Codes: A1=1, A2=01, A3=000, A4=0010, A5=00110, A6=00111.
   - Required: bit_ready=1 the next cycle.
   - Stream 1,0,0,0 -> gray 1, then gray 3, each one cycle after its last bit.
2. Full alphabet, continuous: stream 1,01,000,0010,00110,00111 with bit_valid held high -> gray_data sequence 1,2,3,4,5,6, exactly 6 strobes, no err.
3. Gaps: stream 0,0,1,1,1 with bit_valid low for 3 cycles between bits -> one gray_valid with 6, one cycle after the fifth bit.
4. Error: load the test-1 table but with the slot-6 mask M=0, then stream 0,0,1,1,1,1,1,1 -> err pulse after bit 8, no gray_valid. A following bit 1 -> gray 1.
5. Mid-codeword reload: send 0,0, reload the same table, send 1 -> gray 1, no err.
6. Bits before load / reset mid-stream:
   - bit_valid pulses before any code_valid -> no outputs.
   - Asserting reset after bits 0,0 -> all outputs 0 and bit_ready=0 until the next load.
